line_window_buffer: RTL and testbench



---
 rtl/line_window_buffer_if.sv | 24 ++
 rtl/line_window_buffer.sv | 90 +++++++++
 tb/tb_line_window_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_window_buffer_if.sv
// Pixel-stream bundle between the edge-detector front end and the line
// window buffer: incoming raster pixels and the outgoing vertical columns.
interface line_window_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 3,
    parameter int ADDR_W = 7
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     frame_start;
    logic                     out_valid;
    logic [ROWS*DATA_W-1:0]   out_col;
    logic [ADDR_W-1:0]        out_x;

    modport master (
        output in_valid, in_data, frame_start,
        input  out_valid, out_col, out_x
    );

    modport slave (
        input  in_valid, in_data, frame_start,
        output out_valid, out_col, out_x
    );
endinterface

// File: rtl/line_window_buffer.sv
// Multi-line buffer: keeps the last ROWS-1 image lines in circular line
// memories and emits, per accepted pixel, a vertically aligned column of
// ROWS pixels (current pixel in the LSB slice, oldest line in the MSBs).
// Fill tracking masks stale memory content after reset or frame restart.
module line_window_buffer #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 72,
    parameter int ROWS     = 3,
    parameter int ADDR_W   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    line_window_buffer_if.slave  bus
);
    localparam int FILL_W = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(LINE_LEN - 1);

    // Line memories: mem[0] holds the previous line, mem[ROWS-2] the oldest.
    logic [DATA_W-1:0] mem [ROWS-1][LINE_LEN];

    logic [ADDR_W-1:0]        col;
    logic [FILL_W-1:0]        rows_filled;

    logic [ADDR_W-1:0]        x_eff;
    logic [FILL_W-1:0]        fill_eff;
    logic [ADDR_W-1:0]        col_next;
    logic [FILL_W-1:0]        fill_next;
    logic [ROWS*DATA_W-1:0]   col_vec;

    logic                     vld_p1;
    logic [ROWS*DATA_W-1:0]   out_col_p1;
    logic [ADDR_W-1:0]        out_x_p1;

    // Effective column/fill after frame restart, and pointer advance with wrap.
    always_comb begin
        x_eff     = bus.frame_start ? '0 : col;
        fill_eff  = bus.frame_start ? '0 : rows_filled;
        col_next  = x_eff + ADDR_W'(1);
        fill_next = fill_eff;
        if (x_eff == X_LAST) begin
            col_next = '0;
            if (fill_eff != FILL_MAX) begin
                fill_next = fill_eff + FILL_W'(1);
            end
        end
    end

    // Assemble the column: current pixel plus the stored pixels above it.
    always_comb begin
        col_vec = '0;
        col_vec[DATA_W-1:0] = bus.in_data;
        for (int k = 1; k < ROWS; k++) begin
            col_vec[k*DATA_W +: DATA_W] = mem[k-1][x_eff];
        end
    end

    // Column pointer, fill tracking and registered column output.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            rows_filled <= '0;
            vld_p1      <= 1'b0;
            out_col_p1  <= '0;
            out_x_p1    <= '0;
        end else begin
            vld_p1 <= bus.in_valid && (fill_eff >= FILL_MAX);
            if (bus.in_valid) begin
                col         <= col_next;
                rows_filled <= fill_next;
                out_col_p1  <= col_vec;
                out_x_p1    <= x_eff;
            end
        end
    end

    // Vertical cascade: each line shifts one memory deeper at the same x.
    always_ff @(posedge clk) begin
        if (!rst && bus.in_valid) begin
            mem[0][x_eff] <= bus.in_data;
            for (int k = 1; k < ROWS - 1; k++) begin
                mem[k][x_eff] <= mem[k-1][x_eff];
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_col   = out_col_p1;
    assign bus.out_x     = out_x_p1;
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: a small config (8b, 4 px/line, 3 rows) for
// the corner cases and the wide config (10b, 72 px/line, 5 rows) for depth.
module tb_line_window_buffer;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    line_window_buffer_if #(.DATA_W(8),  .ROWS(3), .ADDR_W(2)) bus_a ();
    line_window_buffer_if #(.DATA_W(10), .ROWS(5), .ADDR_W(7)) bus_b ();

    line_window_buffer #(.DATA_W(8), .LINE_LEN(4), .ROWS(3), .ADDR_W(2)) dut_a (
        .clk (clk), .rst (rst_a), .bus (bus_a.slave)
    );
    line_window_buffer #(.DATA_W(10), .LINE_LEN(72), .ROWS(5), .ADDR_W(7)) dut_b (
        .clk (clk), .rst (rst_b), .bus (bus_b.slave)
    );

    typedef struct {
        logic        v;
        logic [63:0] col;
        int          x;
    } exp_t;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        fs;
        logic        ev;
        logic [23:0] ecol;
        int          ex;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_a;
    logic [7:0] last_d_a;
    vec_t tab[16];

    // Reference model: pixels stored by (line-within-frame, x).
    logic [7:0] hist_a [16][4];
    int ma_line, ma_x;
    logic [9:0] hist_b [8][72];
    int mb_line, mb_x;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_a(input logic [7:0] d, input logic fs, output exp_t e);
        if (fs) begin
            ma_line = 0;
            ma_x    = 0;
        end
        hist_a[ma_line % 16][ma_x] = d;
        e.x   = ma_x;
        e.v   = (ma_line >= 2);
        e.col = '0;
        for (int k = 0; k < 3; k++) begin
            if (ma_line >= k) e.col[k*8 +: 8] = hist_a[(ma_line - k) % 16][ma_x];
        end
        ma_x++;
        if (ma_x == 4) begin
            ma_x = 0;
            ma_line++;
        end
    endtask

    task automatic model_b(input logic [9:0] d, input logic fs, output exp_t e);
        if (fs) begin
            mb_line = 0;
            mb_x    = 0;
        end
        hist_b[mb_line % 8][mb_x] = d;
        e.x   = mb_x;
        e.v   = (mb_line >= 4);
        e.col = '0;
        for (int k = 0; k < 5; k++) begin
            if (mb_line >= k) e.col[k*10 +: 10] = hist_b[(mb_line - k) % 8][mb_x];
        end
        mb_x++;
        if (mb_x == 72) begin
            mb_x = 0;
            mb_line++;
        end
    endtask

    task automatic cyc_a(input logic v, input logic [7:0] d, input logic fs,
                         input logic use_tab, input exp_t tab_e);
        exp_t e;
        exp_t m;
        bus_a.in_valid    = v;
        bus_a.in_data     = d;
        bus_a.frame_start = fs;
        if (v) begin
            model_a(d, fs, m);
            q_a.push_back(use_tab ? tab_e : m);
        end
        @(posedge clk);
        #1;
        if (v) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_queue: got empty queue expected one entry");
            end else begin
                e = q_a.pop_front();
                chk("a_valid", 64'(bus_a.out_valid), 64'(e.v));
                chk("a_x", 64'(bus_a.out_x), 64'(e.x));
                if (e.v) chk("a_col", 64'(bus_a.out_col), e.col);
                else     chk("a_slice0", 64'(bus_a.out_col[7:0]), 64'(d));
                last_a   = e;
                last_d_a = d;
            end
        end else begin
            chk("a_gap_valid", 64'(bus_a.out_valid), 64'(0));
            chk("a_gap_x", 64'(bus_a.out_x), 64'(last_a.x));
            if (last_a.v) chk("a_gap_col", 64'(bus_a.out_col), last_a.col);
            else          chk("a_gap_slice0", 64'(bus_a.out_col[7:0]), 64'(last_d_a));
        end
        bus_a.in_valid    = 1'b0;
        bus_a.frame_start = 1'b0;
    endtask

    task automatic px_a(input logic [7:0] d, input logic fs);
        exp_t dummy;
        dummy = '{v: 1'b0, col: 64'd0, x: 0};
        cyc_a(1'b1, d, fs, 1'b0, dummy);
    endtask

    task automatic gap_a();
        exp_t dummy;
        dummy = '{v: 1'b0, col: 64'd0, x: 0};
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0, dummy);
    endtask

    // Hold reset for n cycles with the given input activity; outputs must be zero.
    task automatic reset_a(input int n, input logic v);
        rst_a             = 1'b1;
        bus_a.in_valid    = v;
        bus_a.in_data     = 8'hEE;
        bus_a.frame_start = v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("a_rst_valid", 64'(bus_a.out_valid), 64'(0));
            chk("a_rst_col", 64'(bus_a.out_col), 64'(0));
            chk("a_rst_x", 64'(bus_a.out_x), 64'(0));
        end
        rst_a             = 1'b0;
        bus_a.in_valid    = 1'b0;
        bus_a.frame_start = 1'b0;
        ma_line  = 0;
        ma_x     = 0;
        q_a.delete();
        last_a   = '{v: 1'b0, col: 64'd0, x: 0};
        last_d_a = 8'h00;
    endtask

    task automatic px_b(input logic [9:0] d, input logic fs);
        exp_t e;
        exp_t m;
        bus_b.in_valid    = 1'b1;
        bus_b.in_data     = d;
        bus_b.frame_start = fs;
        model_b(d, fs, m);
        q_b.push_back(m);
        @(posedge clk);
        #1;
        if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_queue: got empty queue expected one entry");
        end else begin
            e = q_b.pop_front();
            chk("b_valid", 64'(bus_b.out_valid), 64'(e.v));
            chk("b_x", 64'(bus_b.out_x), 64'(e.x));
            if (e.v) chk("b_col", 64'(bus_b.out_col), e.col);
            else     chk("b_slice0", 64'(bus_b.out_col[9:0]), 64'(d));
        end
        bus_b.in_valid    = 1'b0;
        bus_b.frame_start = 1'b0;
    endtask

    initial begin
        exp_t te;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.frame_start = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.frame_start = 1'b0;
        ma_line = 0; ma_x = 0; mb_line = 0; mb_x = 0;

        // Stream 0..15 on the small config: column = {p-8, p-4, p} once filled.
        for (int i = 0; i < 16; i++) begin
            tab[i].v    = 1'b1;
            tab[i].d    = 8'(i);
            tab[i].fs   = (i == 0);
            tab[i].ev   = (i >= 8);
            tab[i].ecol = (i >= 8) ? {8'(i - 8), 8'(i - 4), 8'(i)} : 24'h0;
            tab[i].ex   = i % 4;
        end

        // Reset then idle.
        reset_a(3, 1'b0);
        gap_a();
        gap_a();

        // Table-driven fill and stream.
        for (int i = 0; i < 16; i++) begin
            te = '{v: tab[i].ev, col: 64'(tab[i].ecol), x: tab[i].ex};
            cyc_a(tab[i].v, tab[i].d, tab[i].fs, 1'b1, te);
        end

        // Same stream with a gap after every pixel.
        for (int i = 0; i < 16; i++) begin
            px_a(8'(i), i == 0);
            gap_a();
        end

        // Frame restart mid-line: pixel 10 restarts at x=0, pointer continues at 1.
        for (int i = 0; i < 10; i++) px_a(8'(8'h30 + i), i == 0);
        px_a(8'hAA, 1'b1);
        chk("a_restart_x", 64'(bus_a.out_x), 64'(0));
        chk("a_restart_valid", 64'(bus_a.out_valid), 64'(0));
        px_a(8'hAB, 1'b0);
        chk("a_restart_next_x", 64'(bus_a.out_x), 64'(1));
        for (int i = 0; i < 12; i++) px_a(8'(8'hB0 + i), 1'b0);

        // Wrap and frame_start in the same cycle: frame_start wins.
        px_a(8'h50, 1'b1);
        px_a(8'h51, 1'b0);
        px_a(8'h52, 1'b0);
        px_a(8'h53, 1'b1);
        chk("a_wrapfs_x", 64'(bus_a.out_x), 64'(0));
        px_a(8'h54, 1'b0);
        chk("a_wrapfs_next_x", 64'(bus_a.out_x), 64'(1));

        // Reset mid-operation with a pixel presented, then resume without frame_start.
        for (int i = 0; i < 9; i++) px_a(8'(8'h60 + i), i == 0);
        reset_a(1, 1'b1);
        for (int i = 0; i < 16; i++) px_a(8'(8'h20 + i), 1'b0);
        chk("a_resume_last_col", 64'(bus_a.out_col), 64'h272B2F);

        // Wide config: five lines of line*100+x.
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b_rst_valid", 64'(bus_b.out_valid), 64'(0));
        chk("b_rst_col", 64'(bus_b.out_col), 64'(0));
        rst_b = 1'b0;
        for (int ln = 0; ln < 5; ln++) begin
            for (int x = 0; x < 72; x++) begin
                px_b(10'(ln * 100 + x), (ln == 0) && (x == 0));
                if (ln == 4 && x == 0) begin
                    chk("b_first_valid", 64'(bus_b.out_valid), 64'(1));
                    chk("b_first_col", 64'(bus_b.out_col),
                        64'({10'd0, 10'd100, 10'd200, 10'd300, 10'd400}));
                end
                if (ln == 3 && x == 71) begin
                    chk("b_prefill_valid", 64'(bus_b.out_valid), 64'(0));
                end
                if (ln == 4 && x == 71) begin
                    chk("b_last_col", 64'(bus_b.out_col),
                        64'({10'd71, 10'd171, 10'd271, 10'd371, 10'd471}));
                    chk("b_last_x", 64'(bus_b.out_x), 64'(71));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
